seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 124 ++++++++++++
 tb/tb_seg7_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display
//   (MM:SS). Each digit gets one scan slot of SCAN_DIV+1 clocks. The first
//   BLANK_CYC clocks of a slot are blanked to suppress ghosting. The BCD
//   input is shadowed once per frame so that a frame is never torn. The
//   decimal point of the tens-of-seconds digit serves as a blinking colon.
//
// Parameters
//   SCAN_DIV   scan-timer terminal count (slot = SCAN_DIV+1 clocks)
//   BLANK_CYC  blank clocks at the start of each slot (0 < BLANK_CYC < SCAN_DIV)
//   HALF_SEC   blink-timer terminal count (blink phase = HALF_SEC+1 clocks)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   disp_num  BCD {tens-min, min, tens-sec, sec}
//   lzb_en    1 = blank the tens-of-minutes digit when it is zero
//   sel       digit enables, active-low, bit0 = seconds digit
//   seg       segments, active-low, {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_scan #(
  parameter logic [24:0] SCAN_DIV  = 25'd24_999,
  parameter logic [24:0] BLANK_CYC = 25'd250,
  parameter logic [24:0] HALF_SEC  = 25'd12_499_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] disp_num,
  input  logic        lzb_en,
  output logic [3:0]  sel,
  output logic [7:0]  seg
);

  logic [24:0] cnt;
  logic [1:0]  idx;
  logic [15:0] shd;
  logic [24:0] blink_cnt;
  logic        phase;

  logic        tick;
  logic        blink_wrap;
  logic [3:0]  nib;
  logic [3:0]  sel_dec;
  logic [7:0]  dec;
  logic        blank;
  logic        colon_on;
  logic [3:0]  sel_nxt;
  logic [7:0]  seg_nxt;

  assign tick       = (cnt == SCAN_DIV);
  assign blink_wrap = (blink_cnt == HALF_SEC);

  // Next-output logic: everything here is a function of the current register
  // state (plus the live lzb_en), and is registered into sel/seg below.
  always_comb begin
    nib     = 4'h0;
    sel_dec = 4'hF;
    case (idx)
      2'd0: begin nib = shd[3:0];   sel_dec = 4'b1110; end
      2'd1: begin nib = shd[7:4];   sel_dec = 4'b1101; end
      2'd2: begin nib = shd[11:8];  sel_dec = 4'b1011; end
      2'd3: begin nib = shd[15:12]; sel_dec = 4'b0111; end
      default: begin nib = 4'h0;    sel_dec = 4'hF;    end
    endcase

    // Active-low patterns with dp off; non-BCD nibbles show a dash.
    case (nib)
      4'd0:    dec = 8'hC0;
      4'd1:    dec = 8'hF9;
      4'd2:    dec = 8'hA4;
      4'd3:    dec = 8'hB0;
      4'd4:    dec = 8'h99;
      4'd5:    dec = 8'h92;
      4'd6:    dec = 8'h82;
      4'd7:    dec = 8'hF8;
      4'd8:    dec = 8'h80;
      4'd9:    dec = 8'h90;
      default: dec = 8'hBF;
    endcase

    // Anti-ghost blank window, or a suppressed leading zero (whole slot).
    blank    = (cnt < BLANK_CYC) ||
               (lzb_en && (idx == 2'd3) && (shd[15:12] == 4'h0));
    colon_on = (idx == 2'd2) && phase;

    sel_nxt = 4'hF;
    seg_nxt = 8'hFF;
    if (!blank) begin
      sel_nxt = sel_dec;
      seg_nxt = {~colon_on, dec[6:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      idx       <= 2'd0;
      shd       <= 16'h0000;
      blink_cnt <= '0;
      phase     <= 1'b0;
      sel       <= 4'hF;
      seg       <= 8'hFF;
    end else begin
      cnt <= tick ? 25'd0 : cnt + 25'd1;
      if (tick) begin
        idx <= idx + 2'd1;
        // Frame boundary: latch the next frame's digits in one go.
        if (idx == 2'd3) shd <= disp_num;
      end

      if (blink_wrap) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 25'd1;
      end

      sel <= sel_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
//   Directed bench for seg7_scan with SCAN_DIV=7, BLANK_CYC=2, HALF_SEC=99.
//   After a reset release on a falling edge, output cycle k (sampled on the
//   falling edge after the k-th rising edge) belongs to slot (k-1)/8; the
//   first two cycles of each slot are blank. A frame is 32 cycles; frame 0
//   always shows the reset shadow (0000), frame 1 shows disp_num. The colon
//   phase affects outputs from cycle 101 to 200.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

  logic        clk;
  logic        rst;
  logic [15:0] disp_num;
  logic        lzb_en;
  logic [3:0]  sel;
  logic [7:0]  seg;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan #(
    .SCAN_DIV  (25'd7),
    .BLANK_CYC (25'd2),
    .HALF_SEC  (25'd99)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .disp_num (disp_num),
    .lzb_en   (lzb_en),
    .sel      (sel),
    .seg      (seg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got sel/seg=%h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Holds reset for a few cycles, checks the reset outputs, releases on a
  // falling edge so the next rising edge is output cycle 1.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    step(3);
    check({tag, " reset"}, {sel, seg}, {4'hF, 8'hFF});
    rst = 1'b1;
  endtask

  // Checks slot positions first..last (0..7); positions 0,1 are blank.
  task automatic check_cycles(input string tag, input logic [3:0] es,
                              input logic [7:0] eg, input int first,
                              input int last);
    for (int i = first; i <= last; i++) begin
      step(1);
      if (i < 2)
        check($sformatf("%s c%0d", tag, i), {sel, seg}, {4'hF, 8'hFF});
      else
        check($sformatf("%s c%0d", tag, i), {sel, seg}, {es, eg});
      check($sformatf("%s one_hot c%0d", tag, i),
            {11'd0, ($countones(~sel) <= 1)}, 12'd1);
    end
  endtask

  task automatic check_slot(input string tag, input logic [3:0] es,
                            input logic [7:0] eg);
    check_cycles(tag, es, eg, 0, 7);
  endtask

  task automatic check_zero_frame(input string tag);
    check_slot({tag, " f0 s0"}, 4'hE, 8'hC0);
    check_slot({tag, " f0 s1"}, 4'hD, 8'hC0);
    check_slot({tag, " f0 s2"}, 4'hB, 8'hC0);
    check_slot({tag, " f0 s3"}, 4'h7, 8'hC0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b0;
    disp_num = 16'h0000;
    lzb_en   = 1'b0;

    // Decode/scan with 5937, then asynchronous reset mid idx2 slot.
    disp_num = 16'h5937;
    do_reset("dec");
    check_zero_frame("dec");
    check_slot("dec f1 s0", 4'hE, 8'hF8);
    check_slot("dec f1 s1", 4'hD, 8'hB0);
    check_slot("dec f1 s2", 4'hB, 8'h90);
    check_slot("dec f1 s3", 4'h7, 8'h92);
    step(16);                                    // cycles 65..80
    check_cycles("rst pre", 4'hB, 8'h90, 0, 3);  // cycles 81..84
    #2 rst = 1'b0;
    #1 check("rst async", {sel, seg}, {4'hF, 8'hFF});
    step(2);
    check("rst held", {sel, seg}, {4'hF, 8'hFF});
    rst = 1'b1;
    check_zero_frame("rst post");

    // Tear-free: change input during idx1 of frame 1.
    disp_num = 16'h1234;
    do_reset("tear");
    step(32);
    check_slot("tear f1 s0", 4'hE, 8'h99);
    check_cycles("tear f1 s1a", 4'hD, 8'hB0, 0, 3);
    disp_num = 16'h5678;
    check_cycles("tear f1 s1b", 4'hD, 8'hB0, 4, 7);
    check_slot("tear f1 s2", 4'hB, 8'hA4);
    check_slot("tear f1 s3", 4'h7, 8'hF9);
    check_slot("tear f2 s0", 4'hE, 8'h80);
    check_slot("tear f2 s1", 4'hD, 8'hF8);
    check_slot("tear f2 s2", 4'hB, 8'h82);
    check_slot("tear f2 s3", 4'h7, 8'h92);

    // Leading-zero blanking, then lzb_en dropped (sampled live).
    disp_num = 16'h0905;
    lzb_en   = 1'b1;
    do_reset("lzb");
    step(32);
    check_slot("lzb f1 s0", 4'hE, 8'h92);
    check_slot("lzb f1 s1", 4'hD, 8'hC0);
    check_slot("lzb f1 s2", 4'hB, 8'h90);
    check_slot("lzb f1 s3", 4'hF, 8'hFF);
    lzb_en = 1'b0;
    check_slot("nolzb f2 s0", 4'hE, 8'h92);
    check_slot("nolzb f2 s1", 4'hD, 8'hC0);
    check_slot("nolzb f2 s2", 4'hB, 8'h90);
    check_slot("nolzb f2 s3", 4'h7, 8'hC0);

    // Invalid BCD dash and colon blink.
    disp_num = 16'h00A0;
    do_reset("col");
    step(32);
    check_slot("col f1 s0", 4'hE, 8'hC0);
    check_slot("col f1 s1", 4'hD, 8'hBF);
    check_slot("col f1 s2", 4'hB, 8'hC0);
    check_slot("col f1 s3", 4'h7, 8'hC0);
    step(32);                                    // frame 2
    check_slot("col f3 s0", 4'hE, 8'hC0);
    check_slot("col f3 s1", 4'hD, 8'hBF);
    check_slot("col f3 s2", 4'hB, 8'h40);
    check_slot("col f3 s3", 4'h7, 8'hC0);
    step(64);                                    // frames 4, 5
    check_slot("col f6 s0", 4'hE, 8'hC0);
    check_slot("col f6 s1", 4'hD, 8'hBF);
    check_slot("col f6 s2", 4'hB, 8'hC0);
    check_slot("col f6 s3", 4'h7, 8'hC0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
